// File: rtl/ethernet_frame_rx.sv
// rtl/ethernet_frame_rx.sv - MII nibble receive back end: SFD hunt, length checks, commit/rollback frame FIFO.
// Optional destination-address filter enabled by defining ETH_DEST_FILTER_EN.
module ethernet_frame_rx #(
    parameter int          ADDR_W   = 11,
    parameter int          LEN_W    = 11,
    parameter int          PRE_MIN  = 2,
    parameter int          MIN_LEN  = 64,
    parameter int          MAX_LEN  = 1518,
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             nibble_ready,
    input  logic [3:0]       nibble,
    input  logic             last_nibble,
    input  logic             rd,
    output logic [7:0]       r_data,
    output logic             empty,
    output logic             full,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic [3:0]       frame_err
);
    localparam int PC_W = $clog2(PRE_MIN + 2);

    typedef enum logic [1:0] {IDLE, HUNT, PAYLOAD, DROP} state_t;

    state_t            state_q, state_d;
    logic              phase_q, bvld_q, end_q, odd_q;
    logic [3:0]        lo_q;
    logic [7:0]        byte_q;
    logic [PC_W-1:0]   pre_q, pre_d;
    logic [LEN_W-1:0]  len_q, len_d, len_inc;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, commit_q, commit_d, rd_ptr_q;
    logic              ovf_q, ovf_d, ovs_q, ovs_d, filt_q, filt_d;
    logic              done_d;
    logic [LEN_W-1:0]  flen_d;
    logic [3:0]        ferr_d, err;
    logic              we;
    logic [7:0]        mem [2**ADDR_W];

`ifdef ETH_DEST_FILTER_EN
    logic              mac_ok_q, mac_ok_d, bc_ok_q, bc_ok_d;
    logic [5:0]        sh;
    logic [7:0]        mac_b;
`else
    logic              unused_mac;
    assign unused_mac = ^MAC_ADDR;
`endif

    assign empty  = (rd_ptr_q == commit_q);
    assign full   = (ADDR_W'(wr_ptr_q + 1'b1) == rd_ptr_q);
    assign r_data = empty ? 8'h00 : mem[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        commit_d = commit_q;
        ovf_d    = ovf_q;
        ovs_d    = ovs_q;
        filt_d   = filt_q;
        done_d   = 1'b0;
        flen_d   = frame_len;
        ferr_d   = frame_err;
        err      = 4'b0000;
        we       = 1'b0;
        len_inc  = (&len_q) ? len_q : len_q + 1'b1;
`ifdef ETH_DEST_FILTER_EN
        mac_ok_d = mac_ok_q;
        bc_ok_d  = bc_ok_q;
        sh       = 6'(8 * (5 - int'(len_q[2:0])));
        mac_b    = 8'(MAC_ADDR >> sh);
`endif
        case (state_q)
            IDLE: begin
                pre_d = '0;
                if (start) state_d = HUNT;
            end
            HUNT: begin
                if (!start) begin
                    state_d = IDLE;
                end else if (end_q) begin
                    pre_d = '0;
                end else if (bvld_q) begin
                    if (byte_q == 8'h55) begin
                        if (pre_q < PC_W'(PRE_MIN)) pre_d = pre_q + 1'b1;
                    end else if (byte_q == 8'hD5 && pre_q >= PC_W'(PRE_MIN)) begin
                        state_d  = PAYLOAD;
                        wr_ptr_d = commit_q;
                        len_d    = '0;
                        ovf_d    = 1'b0;
                        ovs_d    = 1'b0;
                        filt_d   = 1'b0;
                        pre_d    = '0;
`ifdef ETH_DEST_FILTER_EN
                        mac_ok_d = 1'b1;
                        bc_ok_d  = 1'b1;
`endif
                    end else begin
                        pre_d = '0;
                    end
                end
            end
            PAYLOAD, DROP: begin
                if (bvld_q) begin
                    len_d = len_inc;
                    if (state_q == PAYLOAD) begin
                        // The overflowing byte is lost even if a read frees a slot this cycle.
                        if (full) begin
                            ovf_d   = 1'b1;
                            state_d = DROP;
                        end else begin
                            we       = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                        if (len_inc > LEN_W'(MAX_LEN)) begin
                            ovs_d   = 1'b1;
                            state_d = DROP;
                        end
`ifdef ETH_DEST_FILTER_EN
                        if (len_q < LEN_W'(6)) begin
                            mac_ok_d = mac_ok_q && (byte_q == mac_b);
                            bc_ok_d  = bc_ok_q && (byte_q == 8'hFF);
                            if (len_q == LEN_W'(5) && !mac_ok_d && !bc_ok_d) begin
                                filt_d  = 1'b1;
                                state_d = DROP;
                            end
                        end
`endif
                    end
                end
                if (end_q) begin
                    err     = {odd_q, ovs_d, (len_d < LEN_W'(MIN_LEN)), ovf_d};
                    state_d = start ? HUNT : IDLE;
                    pre_d   = '0;
                    if (!filt_d && err == 4'b0000) commit_d = wr_ptr_d;
                    else                           wr_ptr_d = commit_q;
                    if (!filt_d) begin
                        done_d = 1'b1;
                        flen_d = len_d;
                        ferr_d = err;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= 1'b0;
            bvld_q     <= 1'b0;
            end_q      <= 1'b0;
            odd_q      <= 1'b0;
            lo_q       <= '0;
            byte_q     <= '0;
            pre_q      <= '0;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            commit_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            ovs_q      <= 1'b0;
            filt_q     <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            frame_err  <= '0;
`ifdef ETH_DEST_FILTER_EN
            mac_ok_q   <= 1'b0;
            bc_ok_q    <= 1'b0;
`endif
        end else begin
            bvld_q <= 1'b0;
            end_q  <= 1'b0;
            odd_q  <= 1'b0;
            if (nibble_ready) begin
                if (phase_q) begin
                    byte_q  <= {nibble, lo_q};
                    bvld_q  <= 1'b1;
                    phase_q <= 1'b0;
                    end_q   <= last_nibble;
                end else begin
                    lo_q    <= nibble;
                    phase_q <= !last_nibble;
                    end_q   <= last_nibble;
                    odd_q   <= last_nibble;
                end
            end
            state_q    <= state_d;
            pre_q      <= pre_d;
            len_q      <= len_d;
            wr_ptr_q   <= wr_ptr_d;
            commit_q   <= commit_d;
            ovf_q      <= ovf_d;
            ovs_q      <= ovs_d;
            filt_q     <= filt_d;
            frame_done <= done_d;
            frame_len  <= flen_d;
            frame_err  <= ferr_d;
            if (rd && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef ETH_DEST_FILTER_EN
            mac_ok_q   <= mac_ok_d;
            bc_ok_q    <= bc_ok_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= byte_q;
    end
endmodule

// File: tb/tb_ethernet_frame_rx.sv
// tb/tb_ethernet_frame_rx.sv - self-checking bench for ethernet_frame_rx (default and ADDR_W=4/PRE_MIN=3/MIN_LEN=1 instances).
module tb_ethernet_frame_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic        nr    [2];
    logic        ln    [2];
    logic        rd    [2];
    logic [3:0]  nib   [2];
    logic [7:0]  rdata [2];
    logic        empty [2];
    logic        full  [2];
    logic        fdone [2];
    logic [10:0] flen  [2];
    logic [3:0]  ferr  [2];

    int tests = 0;
    int fails = 0;
    byte unsigned q0[$];
    byte unsigned q1[$];

`ifdef ETH_DEST_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        int         u;
        int         npre;
        int         len;
        int         da;
        bit         extra;
        bit         exp_done;
        logic [3:0] exp_err;
        int         exp_len;
    } vec_t;

    vec_t vt [15];

    always #5 clk = ~clk;

    ethernet_frame_rx u_a (
        .clk(clk), .reset(rst), .start(start[0]), .nibble_ready(nr[0]), .nibble(nib[0]),
        .last_nibble(ln[0]), .rd(rd[0]), .r_data(rdata[0]), .empty(empty[0]), .full(full[0]),
        .frame_done(fdone[0]), .frame_len(flen[0]), .frame_err(ferr[0])
    );

    ethernet_frame_rx #(.ADDR_W(4), .PRE_MIN(3), .MIN_LEN(1)) u_b (
        .clk(clk), .reset(rst), .start(start[1]), .nibble_ready(nr[1]), .nibble(nib[1]),
        .last_nibble(ln[1]), .rd(rd[1]), .r_data(rdata[1]), .empty(empty[1]), .full(full[1]),
        .frame_done(fdone[1]), .frame_len(flen[1]), .frame_err(ferr[1])
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic byte unsigned pbyte(input int i, input int da, input int seed);
        logic [47:0] d;
        if (i < 6 && da != 0) begin
            d = (da == 1) ? 48'h02_00_00_00_00_01 : (da == 2) ? 48'hFF_FF_FF_FF_FF_FF : 48'h02_00_00_00_00_02;
            return d[8*(5-i) +: 8];
        end
        return 8'(seed + i);
    endfunction

    task automatic send_nib(input int u, input logic [3:0] n, input logic last);
        nib[u] = n;
        ln[u]  = last;
        nr[u]  = 1'b1;
        tick;
        nr[u]  = 1'b0;
        ln[u]  = 1'b0;
    endtask

    task automatic send_byte(input int u, input byte unsigned b, input logic last);
        send_nib(u, b[3:0], 1'b0);
        send_nib(u, b[7:4], last);
    endtask

    task automatic send_frame(input int u, input int npre, input int len, input int da,
                              input bit extra, input int seed, input bit keep);
        byte unsigned b;
        for (int i = 0; i < npre; i++) send_byte(u, 8'h55, 1'b0);
        send_byte(u, 8'hD5, 1'b0);
        for (int i = 0; i < len; i++) begin
            b = pbyte(i, da, seed);
            if (keep) begin
                if (u == 0) q0.push_back(b);
                else        q1.push_back(b);
            end
            send_byte(u, b, !extra && i == len - 1);
        end
        if (extra) send_nib(u, 4'h5, 1'b1);
    endtask

    task automatic await_done(input int u, input bit exp_done, input logic [3:0] exp_err,
                              input int exp_len, input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            tick;
            if (fdone[u] === 1'b1) seen = 1'b1;
        end
        chk({name, " frame_done"}, 32'(seen), 32'(exp_done));
        if (exp_done && seen) begin
            chk({name, " frame_len"}, 32'(flen[u]), exp_len);
            chk({name, " frame_err"}, 32'(ferr[u]), 32'(exp_err));
        end
    endtask

    task automatic drain(input int u, input string name);
        int          n = 0;
        int          sz;
        byte unsigned e;
        while (empty[u] === 1'b0 && n < 4000) begin
            sz = (u == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
                tests++;
                fails++;
                $display("FAIL %s extra byte: got %0h expected none", name, rdata[u]);
                break;
            end
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            chk({name, " r_data"}, 32'(rdata[u]), 32'(e));
            rd[u] = 1'b1;
            tick;
            rd[u] = 1'b0;
            n++;
        end
        sz = (u == 0) ? q0.size() : q1.size();
        chk({name, " bytes missing"}, sz, 0);
        chk({name, " empty"}, 32'(empty[u]), 1);
    endtask

    initial begin
        vec_t v;
        bit   ed;
        vt[0]  = '{0, 7,   64, 0, 1'b0, 1'b1, 4'b0000,   64};
        vt[1]  = '{0, 2,   64, 0, 1'b0, 1'b1, 4'b0000,   64};
        vt[2]  = '{0, 1,   64, 0, 1'b0, 1'b0, 4'b0000,    0};
        vt[3]  = '{1, 2,    8, 0, 1'b0, 1'b0, 4'b0000,    0};
        vt[4]  = '{1, 3,    8, 0, 1'b0, 1'b1, 4'b0000,    8};
        vt[5]  = '{0, 7,   20, 0, 1'b0, 1'b1, 4'b0010,   20};
        vt[6]  = '{0, 7,   63, 0, 1'b0, 1'b1, 4'b0010,   63};
        vt[7]  = '{0, 7,   64, 0, 1'b1, 1'b1, 4'b1000,   64};
        vt[8]  = '{1, 7,   64, 0, 1'b0, 1'b1, 4'b0001,   64};
        vt[9]  = '{1, 7,    8, 0, 1'b0, 1'b1, 4'b0000,    8};
        vt[10] = '{0, 7, 1518, 0, 1'b0, 1'b1, 4'b0000, 1518};
        vt[11] = '{0, 7, 1519, 0, 1'b0, 1'b1, 4'b0100, 1519};
        vt[12] = '{0, 7,   64, 1, 1'b0, 1'b1, 4'b0000,   64};
        vt[13] = '{0, 7,   64, 2, 1'b0, 1'b1, 4'b0000,   64};
        vt[14] = '{0, 7,   64, 3, 1'b0, 1'b1, 4'b0000,   64};

        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; nr[u] = 1'b0; ln[u] = 1'b0; rd[u] = 1'b0; nib[u] = 4'h0;
        end
        repeat (3) tick;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("reset%0d empty", u), 32'(empty[u]), 1);
            chk($sformatf("reset%0d full", u), 32'(full[u]), 0);
            chk($sformatf("reset%0d frame_done", u), 32'(fdone[u]), 0);
            chk($sformatf("reset%0d frame_len", u), 32'(flen[u]), 0);
            chk($sformatf("reset%0d frame_err", u), 32'(ferr[u]), 0);
            chk($sformatf("reset%0d r_data", u), 32'(rdata[u]), 0);
        end
        rst = 1'b0;
        tick;
        start[0] = 1'b1;
        start[1] = 1'b1;
        repeat (2) tick;

        for (int i = 0; i < 15; i++) begin
            v  = vt[i];
            ed = v.exp_done && !(FILT && v.len >= 6 && v.da != 1 && v.da != 2);
            send_frame(v.u, v.npre, v.len, v.da, v.extra, i * 16, ed && v.exp_err == 4'b0000);
            await_done(v.u, ed, v.exp_err, v.exp_len, $sformatf("v%0d", i));
            drain(v.u, $sformatf("v%0d", i));
        end

        send_frame(1, 7, 15, 1, 1'b0, 200, 1'b1);
        await_done(1, 1'b1, 4'b0000, 15, "fill15");
        chk("fill15 full", 32'(full[1]), 1);
        drain(1, "fill15");
        chk("fill15 full after drain", 32'(full[1]), 0);

        send_frame(0, 7, 64, 1, 1'b0, 300, 1'b1);
        await_done(0, 1'b1, 4'b0000, 64, "pre_reset");
        for (int i = 0; i < 7; i++) send_byte(0, 8'h55, 1'b0);
        send_byte(0, 8'hD5, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(0, pbyte(i, 1, 0), 1'b0);
        rst = 1'b1;
        tick;
        chk("midreset empty", 32'(empty[0]), 1);
        chk("midreset frame_done", 32'(fdone[0]), 0);
        chk("midreset frame_err", 32'(ferr[0]), 0);
        chk("midreset frame_len", 32'(flen[0]), 0);
        q0.delete();
        rst = 1'b0;
        repeat (2) tick;
        send_frame(0, 7, 64, 1, 1'b0, 400, 1'b1);
        await_done(0, 1'b1, 4'b0000, 64, "post_reset");
        drain(0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
